tile_map_scroller: RTL and testbench

- Upstream stage of the tile sprite renderer; produces the per-pixel tile index, sprite-enable and horizontal scroll offset that the renderer consumes.
- Holds a writable tile map of MAP_COLS x MAP_ROWS entries.
- Maintains a per-frame horizontal scroll position.
- Emits pipeline-aligned hcount/vcount with every output so the renderer sees coherent inputs.

---
 rtl/tile_map_scroller.sv | 161 ++++++++++++++++
 tb/tb_tile_map_scroller.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_map_scroller.sv
// Tile map scroller: clears a writable tile map after reset, tracks a
// per-frame horizontal scroll position and turns each incoming pixel
// position into a registered tile code / sprite-enable for the renderer.
// All pixel outputs carry one cycle of latency, matching hcount/vcount_out.
module tile_map_scroller #(
    parameter int MAP_COLS  = 64,
    parameter int MAP_ROWS  = 8,
    parameter int ORIGIN_Y  = 0,
    parameter int ACTIVE_W  = 1280,
    parameter int NUM_TILES = 37
) (
    input  logic                                  pixel_clk_in,
    input  logic                                  rst_in,
    input  logic [10:0]                           hcount_in,
    input  logic [9:0]                            vcount_in,
    input  logic                                  new_frame_in,
    input  logic                                  pause_in,
    input  logic [4:0]                            speed_in,
    input  logic                                  map_we_in,
    input  logic [$clog2(MAP_COLS*MAP_ROWS)-1:0]  map_waddr_in,
    input  logic [5:0]                            map_wdata_in,
    output logic [10:0]                           hcount_out,
    output logic [9:0]                            vcount_out,
    output logic [5:0]                            unique_image_index,
    output logic                                  in_sprite,
    output logic [11:0]                           offset_out,
    output logic                                  map_ready_out
);

    localparam int          DEPTH  = MAP_COLS * MAP_ROWS;
    localparam int          AW     = $clog2(DEPTH);
    localparam int          CW     = $clog2(MAP_COLS);
    localparam logic [11:0] W_MASK = 12'(MAP_COLS * 16 - 1);
    localparam logic [5:0]  EMPTY  = 6'h3F;

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   clr_addr_q, clr_addr_d;
    logic [11:0]     scroll_q, scroll_d;

    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [5:0]      mem_wdata;
    logic [5:0]      map_q [DEPTH];

    logic [10:0]     vrel;
    logic            band;
    logic [11:0]     world_x;
    logic [6+CW:0]   rd_full;
    logic [AW-1:0]   rd_addr;
    logic [5:0]      code;
    logic            code_ok;
    logic            lookup_unused;

    logic [10:0]     hcount_q;
    logic [9:0]      vcount_q;
    logic [5:0]      index_q;
    logic            in_sprite_q;

    // State register: reset always restarts the clear sweep from address 0.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_q    <= CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Next state: leave CLEAR once the last map entry has been written.
    always_comb begin
        state_d = state_q;
        if (state_q == CLEAR && clr_addr_q == AW'(DEPTH - 1)) begin
            state_d = RUN;
        end
    end

    // FSM outputs: clear sweep owns the write port in CLEAR, the host in RUN.
    always_comb begin
        clr_addr_d = clr_addr_q;
        mem_we     = 1'b0;
        mem_waddr  = map_waddr_in;
        mem_wdata  = map_wdata_in;
        case (state_q)
            CLEAR: begin
                mem_we     = 1'b1;
                mem_waddr  = clr_addr_q;
                mem_wdata  = EMPTY;
                clr_addr_d = clr_addr_q + 1'b1;
            end
            RUN: begin
                mem_we = map_we_in && ({1'b0, map_waddr_in} < (AW+1)'(DEPTH));
            end
            default: ;
        endcase
    end

    // Tile map write port; no reset so it maps onto distributed RAM.
    always_ff @(posedge pixel_clk_in) begin
        if (mem_we && !rst_in) begin
            map_q[mem_waddr] <= mem_wdata;
        end
    end

    // Scroll update: signed step per frame, wrapped to the map width.
    always_comb begin
        scroll_d = scroll_q;
        if (state_q == RUN && new_frame_in && !pause_in) begin
            scroll_d = (scroll_q + {{7{speed_in[4]}}, speed_in}) & W_MASK;
        end
    end

    // Scroll register.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            scroll_q <= '0;
        end else begin
            scroll_q <= scroll_d;
        end
    end

    // Pixel lookup: the borrow of vcount-ORIGIN_Y lands above the band, so a
    // single unsigned compare covers both band edges. Read is asynchronous,
    // so a same-edge write is seen only on the following cycle.
    always_comb begin
        vrel    = {1'b0, vcount_in} - 11'(ORIGIN_Y);
        band    = (vrel < 11'(MAP_ROWS * 16)) && (hcount_in < 11'(ACTIVE_W));
        world_x = ({1'b0, hcount_in} + scroll_q) & W_MASK;
        rd_full = {vrel[10:4], world_x[CW+3:4]};
        rd_addr = band ? rd_full[AW-1:0] : '0;
        code    = map_q[rd_addr];
        code_ok = band && (code < 6'(NUM_TILES));
    end

    assign lookup_unused = ^{vrel, world_x, rd_full};

    // Registered pixel outputs; tile outputs are forced empty during CLEAR.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            hcount_q    <= '0;
            vcount_q    <= '0;
            index_q     <= '0;
            in_sprite_q <= 1'b0;
        end else begin
            hcount_q    <= hcount_in;
            vcount_q    <= vcount_in;
            index_q     <= (state_q == RUN && code_ok) ? code : 6'd0;
            in_sprite_q <= (state_q == RUN) && code_ok;
        end
    end

    assign hcount_out         = hcount_q;
    assign vcount_out         = vcount_q;
    assign unique_image_index = index_q;
    assign in_sprite          = in_sprite_q;
    assign offset_out         = scroll_q;
    assign map_ready_out      = (state_q == RUN);

endmodule

// File: tb/tb_tile_map_scroller.sv
// Bench for tile_map_scroller: scenario tasks drive stimulus; pixel lookups
// push their expected result onto a queue that a negedge scoreboard pops.
module tb_tile_map_scroller;

  localparam int ORIGIN_Y = 0;

  logic        clk = 1'b0;
  logic        rst_in = 1'b0;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic        new_frame_in = 1'b0;
  logic        pause_in = 1'b0;
  logic [4:0]  speed_in = '0;
  logic        map_we_in = 1'b0;
  logic [8:0]  map_waddr_in = '0;
  logic [5:0]  map_wdata_in = '0;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic [5:0]  unique_image_index;
  logic        in_sprite;
  logic [11:0] offset_out;
  logic        map_ready_out;

  int checks = 0;
  int errors = 0;

  logic [27:0] exp_q[$];
  logic [27:0] sb_exp, sb_got;
  logic        pix_vld = 1'b0;
  logic        sent_q = 1'b0;

  logic [5:0]  bm [512];
  int          scroll_m = 0;
  bit          ready_m = 0;

  tile_map_scroller dut (
    .pixel_clk_in       (clk),
    .rst_in             (rst_in),
    .hcount_in          (hcount_in),
    .vcount_in          (vcount_in),
    .new_frame_in       (new_frame_in),
    .pause_in           (pause_in),
    .speed_in           (speed_in),
    .map_we_in          (map_we_in),
    .map_waddr_in       (map_waddr_in),
    .map_wdata_in       (map_wdata_in),
    .hcount_out         (hcount_out),
    .vcount_out         (vcount_out),
    .unique_image_index (unique_image_index),
    .in_sprite          (in_sprite),
    .offset_out         (offset_out),
    .map_ready_out      (map_ready_out)
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard: a lookup driven before a posedge is compared at the next negedge
  always @(posedge clk) sent_q <= pix_vld;

  always @(negedge clk) begin
    if (sent_q) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: output produced with no expected entry");
      end else begin
        sb_exp = exp_q.pop_front();
        sb_got = {unique_image_index, in_sprite, hcount_out, vcount_out};
        if (sb_got !== sb_exp) begin
          errors++;
          $display("FAIL pix got idx=%0d sp=%0b hc=%0d vc=%0d exp idx=%0d sp=%0b hc=%0d vc=%0d",
                   sb_got[27:22], sb_got[21], sb_got[20:10], sb_got[9:0],
                   sb_exp[27:22], sb_exp[21], sb_exp[20:10], sb_exp[9:0]);
        end
      end
    end
  end

  function automatic logic [27:0] model_pix(input int h, input int v);
    int vr;
    int wx;
    bit band;
    bit ok;
    logic [5:0] c;
    logic [10:0] hh;
    logic [9:0] vv;
    vr   = v - ORIGIN_Y;
    band = (vr >= 0) && (vr < 128) && (h < 1280);
    wx   = (h + scroll_m) % 1024;
    c    = band ? bm[(vr / 16) * 64 + wx / 16] : 6'h3F;
    ok   = ready_m && band && (c < 6'd37);
    hh   = 11'(h);
    vv   = 10'(v);
    return {ok ? c : 6'd0, ok, hh, vv};
  endfunction

  // driver tasks
  task automatic pix(input int h, input int v);
    @(negedge clk);
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    exp_q.push_back(model_pix(h, v));
    pix_vld = 1'b1;
    @(posedge clk);
    #1;
    pix_vld = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    @(negedge clk);
    map_we_in    = 1'b1;
    map_waddr_in = 9'(a);
    map_wdata_in = 6'(d);
    @(posedge clk);
    #1;
    map_we_in = 1'b0;
    if (ready_m) bm[a] = 6'(d);
  endtask

  task automatic frame(input int spd, input bit pse);
    @(negedge clk);
    new_frame_in = 1'b1;
    speed_in     = 5'(spd);
    pause_in     = pse;
    @(posedge clk);
    #1;
    new_frame_in = 1'b0;
    pause_in     = 1'b0;
    if (!pse) scroll_m = (scroll_m + spd) & 1023;
  endtask

  // scenario tasks
  task automatic test_reset_clear();
    int n;
    int bad;
    bit done;
    @(negedge clk);
    rst_in       = 1'b1;
    map_we_in    = 1'b1;
    map_waddr_in = '0;
    map_wdata_in = 6'd5;
    hcount_in    = 11'd3;
    vcount_in    = 10'(ORIGIN_Y + 2);
    speed_in     = 5'd5;
    @(posedge clk);
    #1;
    checks++;
    if (map_ready_out !== 1'b0 || offset_out !== 12'd0 || in_sprite !== 1'b0 ||
        unique_image_index !== 6'd0 || hcount_out !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%0b off=%0d sp=%0b idx=%0d hc=%0d exp all 0",
               map_ready_out, offset_out, in_sprite, unique_image_index, hcount_out);
    end
    for (int i = 0; i < 512; i++) bm[i] = 6'h3F;
    scroll_m = 0;
    ready_m  = 0;
    @(negedge clk);
    rst_in = 1'b0;
    n = 0;
    bad = 0;
    done = 0;
    while (!done && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
      if (map_ready_out === 1'b1) begin
        done = 1;
      end else begin
        if (in_sprite !== 1'b0 || unique_image_index !== 6'd0 ||
            hcount_out !== 11'd3 || vcount_out !== 10'(ORIGIN_Y + 2)) bad++;
        new_frame_in = (n == 100);
      end
    end
    new_frame_in = 1'b0;
    map_we_in    = 1'b0;
    ready_m      = 1;
    checks++;
    if (!done || n != 512) begin
      errors++;
      $display("FAIL clear_cycles got %0d (done=%0b) exp 512", n, done);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clear_outputs got %0d bad cycles exp 0", bad);
    end
    checks++;
    if (offset_out !== 12'd0) begin
      errors++;
      $display("FAIL clear_frame_ignored got off=%0d exp 0", offset_out);
    end
    // write attempted during CLEAR must not have landed at address 0
    pix(3, ORIGIN_Y + 2);
  endtask

  task automatic test_lookup();
    wr(0, 5);
    pix(3, ORIGIN_Y + 2);
    pix(20, ORIGIN_Y + 2);
  endtask

  task automatic test_scroll();
    frame(-1, 0);
    checks++;
    if (offset_out !== 12'd1023) begin
      errors++;
      $display("FAIL scroll_neg_wrap got %0d exp 1023", offset_out);
    end
    frame(2, 0);
    checks++;
    if (offset_out !== 12'd1) begin
      errors++;
      $display("FAIL scroll_pos got %0d exp 1", offset_out);
    end
    frame(2, 1);
    checks++;
    if (offset_out !== 12'd1) begin
      errors++;
      $display("FAIL scroll_pause got %0d exp 1", offset_out);
    end
  endtask

  task automatic test_wrap();
    frame(-5, 0);
    checks++;
    if (offset_out !== 12'd1020) begin
      errors++;
      $display("FAIL scroll_1020 got %0d exp 1020", offset_out);
    end
    wr(0, 7);
    wr(7 * 64, 2);
    pix(4, ORIGIN_Y);
    pix(4, ORIGIN_Y + 127);
    pix(4, ORIGIN_Y + 128);
    checks++;
    if (offset_out !== 12'd1020) begin
      errors++;
      $display("FAIL scroll_hold got %0d exp 1020", offset_out);
    end
  endtask

  task automatic test_empty_codes();
    wr(10, 40);
    wr(74, 6'h3F);
    wr(11, 36);
    wr(15, 3);
    pix(164, ORIGIN_Y);
    pix(164, ORIGIN_Y + 16);
    pix(180, ORIGIN_Y);
    pix(1279, ORIGIN_Y);
    pix(1280, ORIGIN_Y);
  endtask

  task automatic test_back_to_back();
    wr(0, 5);
    @(negedge clk);
    map_we_in    = 1'b1;
    map_waddr_in = 9'd0;
    map_wdata_in = 6'd9;
    hcount_in    = 11'd4;
    vcount_in    = 10'(ORIGIN_Y);
    exp_q.push_back(model_pix(4, ORIGIN_Y));
    pix_vld = 1'b1;
    @(posedge clk);
    #1;
    pix_vld   = 1'b0;
    map_we_in = 1'b0;
    bm[0]     = 6'd9;
    pix(4, ORIGIN_Y);
    pix(5, ORIGIN_Y);
  endtask

  task automatic test_random();
    repeat (20) wr($urandom_range(0, 511), $urandom_range(0, 63));
    repeat (4) begin
      frame(int'($urandom_range(0, 31)) - 16, $urandom_range(0, 3) == 0);
      checks++;
      if (offset_out !== 12'(scroll_m)) begin
        errors++;
        $display("FAIL scroll_rand got %0d exp %0d", offset_out, scroll_m);
      end
      repeat (10) pix($urandom_range(0, 1400), $urandom_range(0, 150));
    end
  endtask

  initial begin
    test_reset_clear();
    test_lookup();
    test_scroll();
    test_wrap();
    test_empty_codes();
    test_back_to_back();
    test_random();
    test_reset_clear();
    pix(4, ORIGIN_Y);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
